// File: rtl/psram_axi_sched.sv
// Purpose: single-beat AXI4 master that shares one PSRAM slave between the record (write) and playback (read) paths.
// Latency: request strobe to AW/W or AR valid is 2 cycles; the done pulse follows the B/R handshake by 1 cycle.
// Backpressure: each path holds one request; an extra strobe is dropped and flagged in sticky req_ovf; a stalled slave holds the FSM.
//
// Ports:
//   clk, S_AXI_ARESETN             : clock, async active-low reset (sync release expected upstream)
//   wr_req/wr_addr/wr_data         : write request strobe with byte address and data
//   wr_done/wr_err                 : one-cycle write completion, error = BRESP != OKAY
//   rd_req/rd_addr                 : read request strobe with byte address
//   rd_done/rd_data/rd_err         : one-cycle read completion, data held until the next rd_done
//   req_ovf, busy                  : sticky dropped-request flag, FSM not idle
//   m_aw*/m_w*/m_b*/m_ar*/m_r*     : AXI4 master channels
// AWLEN/ARLEN=0, AxSIZE=3'b010, INCR bursts, WLAST=1 and zero IDs are tied off at the instance.
module psram_axi_sched #(
    parameter int ADDR_W = 24,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                S_AXI_ARESETN,
    input  logic                wr_req,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_done,
    output logic                wr_err,
    input  logic                rd_req,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_done,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_err,
    output logic                req_ovf,
    output logic                busy,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_AW_W = 3'd1,
        WR_B    = 3'd2,
        RD_AR   = 3'd3,
        RD_R    = 3'd4
    } state_t;

    localparam logic PATH_WR = 1'b0;
    localparam logic PATH_RD = 1'b1;
    // Word alignment: the PSRAM is accessed as 32-bit words only.
    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t              state;
    state_t              state_nxt;
    logic                wr_pend;
    logic                rd_pend;
    logic                rr_last;
    logic                aw_ok;
    logic                w_ok;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic                grant_wr;
    logic                grant_rd;
    logic                wr_active;
    logic                rd_active;

    // Round-robin: on a tie the path that did not go last wins.
    assign grant_wr  = (state == IDLE) && wr_pend && (!rd_pend || (rr_last == PATH_RD));
    assign grant_rd  = (state == IDLE) && rd_pend && (!wr_pend || (rr_last == PATH_WR));
    assign wr_active = (state == WR_AW_W) || (state == WR_B);
    assign rd_active = (state == RD_AR) || (state == RD_R);
    assign m_wstrb   = '1;

    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_wr) begin
                    state_nxt = WR_AW_W;
                end else if (grant_rd) begin
                    state_nxt = RD_AR;
                end
            end
            WR_AW_W: begin
                // Each valid drops independently once its own handshake is done.
                m_awvalid = !aw_ok;
                m_wvalid  = !w_ok;
                if ((aw_ok || m_awready) && (w_ok || m_wready)) begin
                    state_nxt = WR_B;
                end
            end
            WR_B: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    state_nxt = IDLE;
                end
            end
            RD_AR: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_nxt = RD_R;
                end
            end
            RD_R: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_pend   <= 1'b0;
            rd_pend   <= 1'b0;
            rr_last   <= PATH_RD;
            aw_ok     <= 1'b0;
            w_ok      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
            m_awaddr  <= '0;
            m_wdata   <= '0;
            m_araddr  <= '0;
            req_ovf   <= 1'b0;
            wr_done   <= 1'b0;
            wr_err    <= 1'b0;
            rd_done   <= 1'b0;
            rd_err    <= 1'b0;
            rd_data   <= '0;
        end else begin
            // A strobe is only taken when its path is completely free; the grant
            // needs pend=1, so capture and grant never collide on the same path.
            if (wr_req) begin
                if (wr_pend || wr_active) begin
                    req_ovf <= 1'b1;
                end else begin
                    wr_pend   <= 1'b1;
                    wr_addr_q <= wr_addr & WORD_MASK;
                    wr_data_q <= wr_data;
                end
            end
            if (rd_req) begin
                if (rd_pend || rd_active) begin
                    req_ovf <= 1'b1;
                end else begin
                    rd_pend   <= 1'b1;
                    rd_addr_q <= rd_addr & WORD_MASK;
                end
            end

            if (grant_wr) begin
                wr_pend  <= 1'b0;
                rr_last  <= PATH_WR;
                m_awaddr <= wr_addr_q;
                m_wdata  <= wr_data_q;
                aw_ok    <= 1'b0;
                w_ok     <= 1'b0;
            end
            if (grant_rd) begin
                rd_pend  <= 1'b0;
                rr_last  <= PATH_RD;
                m_araddr <= rd_addr_q;
            end

            if (state == WR_AW_W) begin
                if (m_awvalid && m_awready) begin
                    aw_ok <= 1'b1;
                end
                if (m_wvalid && m_wready) begin
                    w_ok <= 1'b1;
                end
            end

            wr_done <= (state == WR_B) && m_bvalid;
            wr_err  <= (state == WR_B) && m_bvalid && (m_bresp != 2'b00);
            rd_done <= (state == RD_R) && m_rvalid;
            rd_err  <= (state == RD_R) && m_rvalid && (m_rresp != 2'b00);
            if ((state == RD_R) && m_rvalid) begin
                rd_data <= m_rdata;
            end
        end
    end

endmodule

// File: tb/tb_psram_axi_sched.sv
module tb_psram_axi_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_done;
    logic        wr_err;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        rd_done;
    logic [31:0] rd_data;
    logic        rd_err;
    logic        req_ovf;
    logic        busy;
    logic [23:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [23:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    psram_axi_sched #(.ADDR_W(24), .DATA_W(32)) dut (
        .clk(clk), .S_AXI_ARESETN(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_done(wr_done), .wr_err(wr_err),
        .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_done(rd_done), .rd_data(rd_data), .rd_err(rd_err),
        .req_ovf(req_ovf), .busy(busy),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- AXI slave model ----------------
    int          cfg_aw_dly = 0;
    logic        cfg_r_stall = 1'b0;
    logic [1:0]  cfg_bresp = 2'b00;
    logic [1:0]  cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = 32'h0;

    initial begin
        int   aw_cnt;
        logic aw_got, w_got, r_pend, rst_s;
        logic s_aw_hs, s_w_hs, s_b_hs, s_ar_hs, s_r_hs;
        aw_cnt = 0; aw_got = 0; w_got = 0; r_pend = 0; rst_s = 1;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        forever begin
            @(negedge clk);
            rst_s   = !rst_n;
            s_aw_hs = m_awvalid && m_awready;
            s_w_hs  = m_wvalid && m_wready;
            s_b_hs  = m_bvalid && m_bready;
            s_ar_hs = m_arvalid && m_arready;
            s_r_hs  = m_rvalid && m_rready;
            if (rst_s) begin
                aw_cnt = 0; aw_got = 0; w_got = 0; r_pend = 0;
            end else if (s_aw_hs) begin
                aw_cnt = 0;
            end else if (m_awvalid) begin
                aw_cnt++;
            end
            @(posedge clk);
            #1;
            m_awready = (aw_cnt >= cfg_aw_dly);
            m_wready  = 1'b1;
            m_arready = 1'b1;
            if (rst_s) begin
                m_bvalid = 0;
                m_rvalid = 0;
            end else begin
                if (s_b_hs) m_bvalid = 0;
                if (s_aw_hs) aw_got = 1;
                if (s_w_hs) w_got = 1;
                if (aw_got && w_got && !m_bvalid) begin
                    m_bvalid = 1; m_bresp = cfg_bresp; aw_got = 0; w_got = 0;
                end
                if (s_r_hs) m_rvalid = 0;
                if (s_ar_hs) r_pend = 1;
                if (r_pend && !m_rvalid && !cfg_r_stall) begin
                    m_rvalid = 1; m_rdata = cfg_rdata; m_rresp = cfg_rresp; r_pend = 0;
                end
            end
        end
    end

    // ---------------- transaction-level model + per-cycle compare ----------------
    // Rules: a request is accepted unless its path already has one outstanding
    // (outstanding = from the strobe up to, not including, its done cycle).
    // A transaction starts 2+ cycles after its strobe, in a cycle that follows an
    // idle cycle; ties go to the path that did not go last. Done pulses follow the
    // response handshake by one cycle.
    logic        wr_out_m, rd_out_m, wr_wait_m, rd_wait_m, flight_m, ovf_m, rr_m;
    int          wr_req_cyc, rd_req_cyc;
    logic [23:0] wr_addr_m, rd_addr_m;
    logic [31:0] wr_data_m, last_rd_m;
    logic        p_b_hs, p_r_hs, p_busy;
    logic [1:0]  p_bresp, p_rresp;
    logic [31:0] p_rdata, p_wdata;
    logic        p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [23:0] p_awaddr, p_araddr;
    logic        prev_idle, el_w, el_r, pick_rd;
    int          aw_hs_cnt = 0;
    int          grant_log[$];

    task automatic model_reset();
        wr_out_m = 0; rd_out_m = 0; wr_wait_m = 0; rd_wait_m = 0;
        flight_m = 0; ovf_m = 0; rr_m = 1; last_rd_m = 0;
        wr_req_cyc = 0; rd_req_cyc = 0;
        wr_addr_m = 0; rd_addr_m = 0; wr_data_m = 0;
        p_b_hs = 0; p_r_hs = 0; p_busy = 0; p_bresp = 0; p_rresp = 0; p_rdata = 0; p_wdata = 0;
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0; p_awaddr = 0; p_araddr = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_reset();
            end else begin
                chk("req_ovf", 32'(req_ovf), 32'(ovf_m));
                prev_idle = !flight_m;
                chk("wr_done", 32'(wr_done), 32'(p_b_hs));
                chk("wr_err", 32'(wr_err), 32'(p_b_hs && (p_bresp != 2'b00)));
                if (p_b_hs) begin wr_out_m = 0; flight_m = 0; end
                chk("rd_done", 32'(rd_done), 32'(p_r_hs));
                chk("rd_err", 32'(rd_err), 32'(p_r_hs && (p_rresp != 2'b00)));
                if (p_r_hs) begin last_rd_m = p_rdata; rd_out_m = 0; flight_m = 0; end
                chk("rd_data", rd_data, last_rd_m);

                el_w = wr_wait_m && (wr_req_cyc <= cyc - 2);
                el_r = rd_wait_m && (rd_req_cyc <= cyc - 2);
                if (prev_idle && (el_w || el_r)) begin
                    pick_rd  = el_r && (!el_w || (rr_m == 1'b0));
                    rr_m     = pick_rd;
                    flight_m = 1;
                    if (pick_rd) begin
                        rd_wait_m = 0;
                        chk("start_arvalid", 32'(m_arvalid), 1);
                        chk("start_araddr", 32'(m_araddr), 32'(rd_addr_m & 24'hFFFFFC));
                    end else begin
                        wr_wait_m = 0;
                        chk("start_awvalid", 32'(m_awvalid), 1);
                        chk("start_wvalid", 32'(m_wvalid), 1);
                        chk("start_awaddr", 32'(m_awaddr), 32'(wr_addr_m & 24'hFFFFFC));
                        chk("start_wdata", m_wdata, wr_data_m);
                        chk("start_wstrb", 32'(m_wstrb), 32'hF);
                    end
                end
                chk("busy", 32'(busy), 32'(flight_m));
                chk("excl", 32'((m_awvalid || m_wvalid) && m_arvalid), 0);
                if (p_awv && !p_awr) begin
                    chk("aw_hold", 32'(m_awvalid), 1);
                    chk("awaddr_hold", 32'(m_awaddr), 32'(p_awaddr));
                end
                if (p_wv && !p_wr) begin
                    chk("w_hold", 32'(m_wvalid), 1);
                    chk("wdata_hold", m_wdata, p_wdata);
                end
                if (p_arv && !p_arr) begin
                    chk("ar_hold", 32'(m_arvalid), 1);
                    chk("araddr_hold", 32'(m_araddr), 32'(p_araddr));
                end
                if (busy && !p_busy) grant_log.push_back(m_arvalid ? 1 : 0);

                if (wr_req) begin
                    if (wr_out_m) ovf_m = 1;
                    else begin
                        wr_out_m = 1; wr_wait_m = 1; wr_req_cyc = cyc;
                        wr_addr_m = wr_addr; wr_data_m = wr_data;
                    end
                end
                if (rd_req) begin
                    if (rd_out_m) ovf_m = 1;
                    else begin
                        rd_out_m = 1; rd_wait_m = 1; rd_req_cyc = cyc; rd_addr_m = rd_addr;
                    end
                end

                if (m_awvalid && m_awready) aw_hs_cnt++;
                p_b_hs = m_bvalid && m_bready; p_bresp = m_bresp;
                p_r_hs = m_rvalid && m_rready; p_rresp = m_rresp; p_rdata = m_rdata;
                p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
                p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata;
                p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
                p_busy = busy;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int sel, input int max, input string name, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if ((sel == 0 && wr_done) || (sel == 1 && rd_done)) begin
                at = cyc;
                break;
            end
        end
        checks++;
        if (at < 0) begin
            errors++;
            $display("FAIL %s: no done pulse within %0d cycles", name, max);
        end
    endtask

    initial begin
        int at, n0, awc, wc, dc;
        rst_n = 0; wr_req = 0; wr_addr = 0; wr_data = 0; rd_req = 0; rd_addr = 0;
        repeat (2) @(negedge clk);
        chk("rst_awvalid", 32'(m_awvalid), 0);
        chk("rst_arvalid", 32'(m_arvalid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ovf", 32'(req_ovf), 0);
        chk("rst_rd_data", rd_data, 0);
        tick(); rst_n = 1;
        repeat (2) tick();

        // 1: single write, slave always ready
        wr_req = 1; wr_addr = 24'h000008; wr_data = 32'hA5A51234;
        tick(); wr_req = 0;
        tick(); @(negedge clk);
        chk("t1_awvalid@2", 32'(m_awvalid), 1);
        chk("t1_wvalid@2", 32'(m_wvalid), 1);
        chk("t1_awaddr", 32'(m_awaddr), 32'h000008);
        chk("t1_wdata", m_wdata, 32'hA5A51234);
        tick(); @(negedge clk);
        chk("t1_bready@3", 32'(m_bready), 1);
        chk("t1_done_early", 32'(wr_done), 0);
        tick(); @(negedge clk);
        chk("t1_wr_done@4", 32'(wr_done), 1);
        chk("t1_wr_err", 32'(wr_err), 0);
        tick(); @(negedge clk);
        chk("t1_done_pulse", 32'(wr_done), 0);

        // 2: single read, unaligned address
        cfg_rdata = 32'hDEADBEEF;
        tick(); rd_req = 1; rd_addr = 24'h00000B;
        tick(); rd_req = 0;
        tick(); @(negedge clk);
        chk("t2_arvalid@2", 32'(m_arvalid), 1);
        chk("t2_araddr", 32'(m_araddr), 32'h000008);
        tick(); @(negedge clk);
        chk("t2_rready@3", 32'(m_rready), 1);
        tick(); @(negedge clk);
        chk("t2_rd_done@4", 32'(rd_done), 1);
        chk("t2_rd_data", rd_data, 32'hDEADBEEF);
        chk("t2_rd_err", 32'(rd_err), 0);
        repeat (2) tick(); @(negedge clk);
        chk("t2_rd_done_low", 32'(rd_done), 0);
        chk("t2_rd_data_held", rd_data, 32'hDEADBEEF);

        // 3: simultaneous requests, four rounds
        grant_log.delete();
        for (int r = 0; r < 4; r++) begin
            cfg_rdata = 32'h1000_0000 + r;
            tick();
            wr_req = 1; wr_addr = 24'h000100 + 24'(r * 4); wr_data = 32'hC0DE_0000 + r;
            rd_req = 1; rd_addr = 24'h000200 + 24'(r * 4);
            tick(); wr_req = 0; rd_req = 0;
            wait_done(1, 30, "t3_rd_done", at);
        end
        chk("t3_grants", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size() && i < 8; i++) begin
            chk($sformatf("t3_grant%0d", i), grant_log[i], i % 2);
        end

        // 4: AWREADY delayed 5 cycles
        cfg_aw_dly = 5;
        tick(); wr_req = 1; wr_addr = 24'h000104; wr_data = 32'h0BAD_F00D;
        tick(); wr_req = 0;
        awc = 0; wc = 0; dc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (m_awvalid) awc++;
            if (m_wvalid) wc++;
            if (wr_done) dc++;
        end
        chk("t4_awvalid_cycles", awc, 6);
        chk("t4_wvalid_cycles", wc, 1);
        chk("t4_done_count", dc, 1);
        cfg_aw_dly = 0;

        // 5: error responses
        cfg_bresp = 2'b10;
        tick(); wr_req = 1; wr_addr = 24'h000010; wr_data = 32'h1;
        tick(); wr_req = 0;
        wait_done(0, 20, "t5_wr_done", at);
        chk("t5_wr_err", 32'(wr_err), 1);
        @(negedge clk);
        chk("t5_wr_err_after", 32'(wr_err), 0);
        cfg_bresp = 2'b00;
        cfg_rresp = 2'b11;
        tick(); rd_req = 1; rd_addr = 24'h000014;
        tick(); rd_req = 0;
        wait_done(1, 20, "t5_rd_done", at);
        chk("t5_rd_err", 32'(rd_err), 1);
        @(negedge clk);
        chk("t5_rd_err_after", 32'(rd_err), 0);
        cfg_rresp = 2'b00;

        // 6: overflow, then reset in the middle of a read
        n0 = aw_hs_cnt;
        tick(); wr_req = 1; wr_addr = 24'h000200; wr_data = 32'h2222;
        tick(); wr_addr = 24'h000300; wr_data = 32'h3333;
        tick(); wr_req = 0;
        @(negedge clk);
        chk("t6_req_ovf", 32'(req_ovf), 1);
        wait_done(0, 20, "t6_wr_done", at);
        repeat (6) @(negedge clk);
        chk("t6_aw_count", aw_hs_cnt - n0, 1);
        cfg_r_stall = 1;
        tick(); rd_req = 1; rd_addr = 24'h000400;
        tick(); rd_req = 0;
        repeat (2) tick();
        @(negedge clk);
        chk("t6_in_rd_r", 32'(m_rready), 1);
        tick(); rst_n = 0;
        @(negedge clk);
        chk("t6_rst_rready", 32'(m_rready), 0);
        chk("t6_rst_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready}), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_ovf", 32'(req_ovf), 0);
        cfg_r_stall = 0;
        repeat (2) tick();
        rst_n = 1;
        repeat (2) tick();
        wr_req = 1; wr_addr = 24'h000500; wr_data = 32'h5555;
        tick(); wr_req = 0;
        wait_done(0, 20, "t6_recover", at);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
